axi_lite_intr_ctrl: RTL and testbench
=====================================

Name: axi_lite_intr_ctrl

Overview:
AXI4-Lite slave interrupt controller for the accelerator. It captures per-source interrupt events, for example the SHA-256 core's "digest done", into status bits. It masks them with global and per-source enables and drives a single `irq` line to the processor. Software reaches it through the interrupt AXI4-Lite port at base `0x44A00000` and acknowledges events with write-1-to-clear.

Parameters:
- `C_S_AXI_DATA_WIDTH`, 32: AXI data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 5: AXI address width; `addr[4:2]` selects the register.
- `C_NUM_OF_INTR`, 1: number of interrupt sources, 1..32.
- `C_INTR_SENSITIVITY`, 32'hFFFFFFFF: per-source mode; 1 = edge, 0 = level.
- `C_INTR_ACTIVE_STATE`, 32'hFFFFFFFF: per-source polarity; 1 = rising edge or high level, 0 = falling edge or low level.
- `C_IRQ_SENSITIVITY`, 1: 1 = level `irq`, 0 = single-cycle pulse `irq`.
- `C_IRQ_ACTIVE_STATE`, 1: active level of `irq`.

Ports:
- `ACLK`, in, 1: clock.
- `ARESETN`, in, 1: asynchronous active-low reset.
- `S_AXI_AWADDR`, in, `C_S_AXI_ADDR_WIDTH`: write address.
- `S_AXI_AWPROT`, in, 3: ignored.
- `S_AXI_AWVALID`, in, 1 / `S_AXI_AWREADY`, out, 1: write-address handshake.
- `S_AXI_WDATA`, in, 32: write data.
- `S_AXI_WSTRB`, in, 4: byte strobes.
- `S_AXI_WVALID`, in, 1 / `S_AXI_WREADY`, out, 1: write-data handshake.
- `S_AXI_BRESP`, out, 2 / `S_AXI_BVALID`, out, 1 / `S_AXI_BREADY`, in, 1: write response.
- `S_AXI_ARADDR`, in, `C_S_AXI_ADDR_WIDTH`: read address.
- `S_AXI_ARPROT`, in, 3: ignored.
- `S_AXI_ARVALID`, in, 1 / `S_AXI_ARREADY`, out, 1: read-address handshake.
- `S_AXI_RDATA`, out, 32 / `S_AXI_RRESP`, out, 2 / `S_AXI_RVALID`, out, 1 / `S_AXI_RREADY`, in, 1: read data.
- `intr_in`, in, `C_NUM_OF_INTR`: interrupt sources, synchronous to `ACLK`.
- `irq`, out, 1: interrupt to processor.

Behaviour:
- Reset values:
  - All ready/valid outputs are 0; `BRESP` and `RRESP` are 0; `RDATA` is 0.
  - `GIER`, `IER` and `ISR` are 0.
  - Edge-detect history holds the inactive level, `~C_INTR_ACTIVE_STATE`.
  - `irq` is `~C_IRQ_ACTIVE_STATE`.
  - Reset mid-transaction abandons the transaction; no response is issued after reset.
- Register map (offsets):
  - `0x00` GIER: bit0 global enable, RW.
  - `0x04` IER: `[C_NUM_OF_INTR-1:0]` per-source enable, RW.
  - `0x08` ISR: raw captured status, RO.
  - `0x0C` IAR: write-1-to-clear ISR bits; reads 0.
  - `0x10` IPR: `ISR & IER`, RO.
  - Offsets `0x14`–`0x1C` read 0 and ignore writes.
  - Bits above `C_NUM_OF_INTR` read 0.
  - Responses are always OKAY (`2'b00`).
- `WSTRB`: a write takes effect only when `WSTRB[0]` = 1; other lanes are ignored because every field lives in byte 0..3 of bit `[N-1:0]`. Full-word writes are expected.
- Write channel:
  - `AWREADY` is 1 while no address is latched and `BVALID` = 0. `WREADY` follows the same rule for data.
  - AW and W may arrive in either order or in the same cycle; each is latched on its handshake.
  - The register update happens in the cycle after both are latched.
  - `BVALID` rises the cycle after the update and holds until `BREADY`.
  - No new AW/W is accepted while `BVALID` = 1.
  - Minimum write latency is AW/W handshake to `BVALID` in 2 cycles.
- Read channel:
  - `ARREADY` = 1 when `RVALID` = 0 and no read is pending.
  - `RVALID` and `RDATA` are registered one cycle after the AR handshake.
  - `RDATA` samples register state at the AR handshake cycle.
  - `RVALID` and `RDATA` hold stable until `RREADY`.
  - Reads and writes proceed independently.
- Capture, per source i:
  - Edge mode: `ISR[i]` is set when `intr_in[i]` moves from inactive to active (compared against the registered previous value).
  - Level mode: `ISR[i]` is set every cycle `intr_in[i]` is active.
  - Capture is independent of the enables.
- Acknowledge: an IAR write with bit i = 1 clears `ISR[i]`. If a capture occurs in the same cycle, the set wins and the bit stays 1. In level mode the bit re-sets while the source remains active.
- `irq` condition: `c = GIER[0] & |(ISR & IER)`.
  - Level mode: `irq` is the registered `c` mapped to `C_IRQ_ACTIVE_STATE`, so it lags an ISR change by one cycle.
  - Pulse mode: `irq` is active for exactly one cycle on each 0→1 transition of `c`.
- Clearing GIER or IER drops level `irq` one cycle after the write update; ISR is not modified.

Test Plan:
1. Reset, then read `0x00`–`0x1C` → all read 0, `RRESP` = 0, `irq` = 0.
2. Write `0x00` = 1 and `0x04` = 1, then pulse `intr_in[0]` high for 1 cycle → `ISR` = 1, `IPR` = 1, `irq` = 1 two cycles after the edge. Write `0x0C` = 1 → `IPR` reads 0 and `irq` = 0.
3. Hold `intr_in[0]` high with `IER` = 0 → `ISR` = 1, `IPR` = 0, `irq` stays 0. Then write `IER` = 1 → `irq` asserts.
4. AW sent 3 cycles before W, then W before AW, then both in the same cycle, with `BREADY` held low for 4 cycles → `BVALID` held, `AWREADY` = 0 until B completes, and each data value is read back correctly.
5. Issue an IAR write to bit0 in the same cycle as a new `intr_in[0]` rising edge → `ISR[0]` remains 1.
6. Set `C_IRQ_SENSITIVITY` = 0 and send two source edges separated by an ack → exactly two single-cycle `irq` pulses. Assert `ARESETN` low mid-write → `BVALID` = 0 and `irq` inactive immediately.

Source files
------------

// File: rtl/axi_lite_intr_ctrl_if.sv
// AXI4-Lite slave-side bundle for the interrupt controller register port.
interface axi_lite_intr_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_lite_intr_ctrl.sv
// AXI4-Lite interrupt controller: captures per-source events into ISR, masks
// them with GIER/IER and drives a single level or pulse irq line.
module axi_lite_intr_ctrl #(
    parameter int          C_S_AXI_DATA_WIDTH  = 32,
    parameter int          C_S_AXI_ADDR_WIDTH  = 5,
    parameter int          C_NUM_OF_INTR       = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFFFFFF,
    parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFFFFFF,
    parameter bit          C_IRQ_SENSITIVITY   = 1'b1,
    parameter bit          C_IRQ_ACTIVE_STATE  = 1'b1
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    axi_lite_intr_ctrl_if.slave      s_axi,
    input  logic [C_NUM_OF_INTR-1:0] intr_in,
    output logic                     irq
);
    localparam int           N    = C_NUM_OF_INTR;
    localparam logic [N-1:0] SENS = C_INTR_SENSITIVITY[N-1:0];
    localparam logic [N-1:0] ACT  = C_INTR_ACTIVE_STATE[N-1:0];

    localparam logic [2:0] REG_GIER = 3'd0;
    localparam logic [2:0] REG_IER  = 3'd1;
    localparam logic [2:0] REG_ISR  = 3'd2;
    localparam logic [2:0] REG_IAR  = 3'd3;
    localparam logic [2:0] REG_IPR  = 3'd4;

    logic                          live_q;
    logic                          aw_lat_q, w_lat_q, bvalid_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]                   wdata_q;
    logic                          wstrb0_q;
    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic                          gier_q;
    logic [N-1:0]                  ier_q, isr_q, prev_q;
    logic                          c_q, irq_q;

    logic                          awready, wready, arready;
    logic                          aw_hs, w_hs, ar_hs, do_wr, wr_en;
    logic [2:0]                    wr_sel;
    logic [N-1:0]                  src_act, prev_act, capture, ack, isr_d;
    logic                          irq_cond, irq_fire;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

    // live_q keeps every ready low while reset is asserted and for one cycle after
    assign awready = live_q & ~aw_lat_q & ~bvalid_q;
    assign wready  = live_q & ~w_lat_q & ~bvalid_q;
    assign arready = live_q & ~rvalid_q;
    assign aw_hs   = s_axi.S_AXI_AWVALID & awready;
    assign w_hs    = s_axi.S_AXI_WVALID & wready;
    assign ar_hs   = s_axi.S_AXI_ARVALID & arready;
    assign do_wr   = aw_lat_q & w_lat_q;
    assign wr_en   = do_wr & wstrb0_q;
    assign wr_sel  = awaddr_q[4:2];

    always_comb begin
        src_act  = ~(intr_in ^ ACT);
        prev_act = ~(prev_q ^ ACT);
        capture  = (SENS & src_act & ~prev_act) | (~SENS & src_act);
        ack      = (wr_en && wr_sel == REG_IAR) ? wdata_q[N-1:0] : '0;
        // a capture in the same cycle as an acknowledge keeps the bit set
        isr_d    = (isr_q & ~ack) | capture;
        irq_cond = gier_q & (|(isr_q & ier_q));
        irq_fire = C_IRQ_SENSITIVITY ? irq_cond : (irq_cond & ~c_q);
        rd_word  = '0;
        case (s_axi.S_AXI_ARADDR[4:2])
            REG_GIER: rd_word[0]     = gier_q;
            REG_IER:  rd_word[N-1:0] = ier_q;
            REG_ISR:  rd_word[N-1:0] = isr_q;
            REG_IPR:  rd_word[N-1:0] = isr_q & ier_q;
            default:  rd_word        = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live_q   <= 1'b0;
            aw_lat_q <= 1'b0;
            w_lat_q  <= 1'b0;
            bvalid_q <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb0_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (aw_hs) begin
                aw_lat_q <= 1'b1;
                awaddr_q <= s_axi.S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_lat_q  <= 1'b1;
                wdata_q  <= s_axi.S_AXI_WDATA;
                wstrb0_q <= s_axi.S_AXI_WSTRB[0];
            end
            if (do_wr) begin
                aw_lat_q <= 1'b0;
                w_lat_q  <= 1'b0;
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gier_q <= 1'b0;
            ier_q  <= '0;
            isr_q  <= '0;
            prev_q <= ~ACT;
            c_q    <= 1'b0;
            irq_q  <= ~C_IRQ_ACTIVE_STATE;
        end else begin
            if (wr_en && wr_sel == REG_GIER) gier_q <= wdata_q[0];
            if (wr_en && wr_sel == REG_IER)  ier_q  <= wdata_q[N-1:0];
            isr_q  <= isr_d;
            prev_q <= intr_in;
            c_q    <= irq_cond;
            irq_q  <= irq_fire ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign irq                 = irq_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_WSTRB,
                           s_axi.S_AXI_ARADDR, awaddr_q, wdata_q};
endmodule

// File: tb/tb_axi_lite_intr_ctrl.sv
// Bench for axi_lite_intr_ctrl: a 4-source level-irq instance checked against a
// cycle model, plus a 1-source pulse-irq instance checked with directed steps.
module tb_axi_lite_intr_ctrl;
    localparam int           N0     = 4;
    localparam logic [31:0]  SENS0  = 32'h0000_0005;
    localparam logic [31:0]  ACT0   = 32'hFFFF_FFFB;
    localparam logic [N0-1:0] SENS_V = SENS0[N0-1:0];
    localparam logic [N0-1:0] ACT_V  = ACT0[N0-1:0];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_intr_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus0 ();
    axi_lite_intr_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus1 ();
    logic [N0-1:0] intr0;
    logic          intr1;
    logic          irq0, irq1;

    axi_lite_intr_ctrl #(
        .C_NUM_OF_INTR(N0), .C_INTR_SENSITIVITY(SENS0), .C_INTR_ACTIVE_STATE(ACT0)
    ) dut0 (.ACLK(clk), .ARESETN(rst_n), .s_axi(bus0), .intr_in(intr0), .irq(irq0));

    axi_lite_intr_ctrl #(
        .C_NUM_OF_INTR(1), .C_IRQ_SENSITIVITY(1'b0)
    ) dut1 (.ACLK(clk), .ARESETN(rst_n), .s_axi(bus1), .intr_in(intr1), .irq(irq1));

    int n_pass = 0, n_fail = 0, n_total = 0;

    // ---------------- reference model of dut0 ----------------
    logic [N0-1:0] m_isr, m_ier, m_prev;
    logic          m_gier, m_irq;
    logic          m_fire = 1'b0, m_strb0 = 1'b0;
    logic [4:0]    m_addr = '0;
    logic [31:0]   m_data = '0;

    function automatic logic [N0-1:0] next_isr(input logic [N0-1:0] isr, input logic [N0-1:0] prev,
                                               input logic [N0-1:0] inp, input logic [N0-1:0] ack);
        logic [N0-1:0] r;
        bit now_on, was_on, hit;
        for (int i = 0; i < N0; i++) begin
            now_on = (inp[i] == ACT_V[i]);
            was_on = (prev[i] == ACT_V[i]);
            hit    = SENS_V[i] ? (now_on && !was_on) : now_on;
            r[i]   = hit || (isr[i] && !ack[i]);
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_isr  <= '0;
            m_ier  <= '0;
            m_gier <= 1'b0;
            m_irq  <= 1'b0;
            m_prev <= ~ACT_V;
        end else begin
            m_irq  <= m_gier && ((m_isr & m_ier) != '0);
            m_isr  <= next_isr(m_isr, m_prev, intr0,
                               (m_fire && m_strb0 && m_addr == 5'h0C) ? m_data[N0-1:0] : '0);
            m_prev <= intr0;
            if (m_fire && m_strb0 && m_addr == 5'h00) m_gier <= m_data[0];
            if (m_fire && m_strb0 && m_addr == 5'h04) m_ier  <= m_data[N0-1:0];
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'h00:   return {31'b0, m_gier};
            5'h04:   return 32'(m_ier);
            5'h08:   return 32'(m_isr);
            5'h10:   return 32'(m_isr & m_ier);
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- pulse monitor for dut1 ----------------
    int p_count = 0, p_len = 0, p_maxlen = 0;
    always @(negedge clk) begin
        if (irq1) begin
            p_len <= p_len + 1;
            if (p_len == 0) p_count <= p_count + 1;
            if (p_len + 1 > p_maxlen) p_maxlen <= p_len + 1;
        end else begin
            p_len <= 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("irq_model", 32'(irq0), 32'(m_irq));
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [N0-1:0] rise_at_commit);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int t = 0;
        bus0.S_AXI_AWADDR = a;
        bus0.S_AXI_WDATA  = d;
        bus0.S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && t < 30) begin
            bus0.S_AXI_AWVALID = !aw_done && (t >= aw_dly);
            bus0.S_AXI_WVALID  = !w_done && (t >= w_dly);
            if (aw_done) check("awready_low_latched", 32'(bus0.S_AXI_AWREADY), 0);
            if (w_done)  check("wready_low_latched", 32'(bus0.S_AXI_WREADY), 0);
            hs_aw = bus0.S_AXI_AWVALID && bus0.S_AXI_AWREADY;
            hs_w  = bus0.S_AXI_WVALID && bus0.S_AXI_WREADY;
            tick();
            aw_done |= hs_aw;
            w_done  |= hs_w;
            t++;
        end
        bus0.S_AXI_AWVALID = 1'b0;
        bus0.S_AXI_WVALID  = 1'b0;
        check("wr_handshake", {30'b0, aw_done, w_done}, 32'h3);
        if (!(aw_done && w_done)) return;
        check("bvalid_early", 32'(bus0.S_AXI_BVALID), 0);
        m_fire = 1'b1; m_addr = a; m_data = d; m_strb0 = strb[0];
        intr0  = intr0 | rise_at_commit;
        tick();
        m_fire = 1'b0;
        check("bvalid_rise", 32'(bus0.S_AXI_BVALID), 1);
        check("bresp", 32'(bus0.S_AXI_BRESP), 0);
        repeat (b_dly) begin
            tick();
            check("bvalid_hold", 32'(bus0.S_AXI_BVALID), 1);
            check("awready_during_b", 32'(bus0.S_AXI_AWREADY), 0);
            check("wready_during_b", 32'(bus0.S_AXI_WREADY), 0);
        end
        bus0.S_AXI_BREADY = 1'b1;
        tick();
        bus0.S_AXI_BREADY = 1'b0;
        check("bvalid_fall", 32'(bus0.S_AXI_BVALID), 0);
    endtask

    task automatic axi_read(input logic [4:0] a, input int r_dly);
        int t = 0;
        bit done = 0;
        logic [31:0] exp = '0;
        bus0.S_AXI_ARADDR  = a;
        bus0.S_AXI_ARVALID = 1'b1;
        while (!done && t < 20) begin
            if (bus0.S_AXI_ARREADY) begin
                done = 1;
                exp  = m_read(a);
            end
            tick();
            t++;
        end
        bus0.S_AXI_ARVALID = 1'b0;
        check("rd_handshake", 32'(done), 1);
        check("rvalid", 32'(bus0.S_AXI_RVALID), 1);
        check($sformatf("rdata_%02h", a), bus0.S_AXI_RDATA, exp);
        check("rresp", 32'(bus0.S_AXI_RRESP), 0);
        repeat (r_dly) begin
            tick();
            check("rdata_hold", bus0.S_AXI_RDATA, exp);
            check("arready_busy", 32'(bus0.S_AXI_ARREADY), 0);
        end
        bus0.S_AXI_RREADY = 1'b1;
        tick();
        bus0.S_AXI_RREADY = 1'b0;
        check("rvalid_fall", 32'(bus0.S_AXI_RVALID), 0);
    endtask

    task automatic axi1_write(input logic [4:0] a, input logic [31:0] d);
        bit ok = 0;
        bus1.S_AXI_AWADDR  = a;
        bus1.S_AXI_WDATA   = d;
        bus1.S_AXI_WSTRB   = 4'hF;
        bus1.S_AXI_AWVALID = 1'b1;
        bus1.S_AXI_WVALID  = 1'b1;
        bus1.S_AXI_BREADY  = 1'b1;
        for (int t = 0; t < 10 && !ok; t++) begin
            ok = bus1.S_AXI_AWREADY && bus1.S_AXI_WREADY;
            @(posedge clk);
            @(negedge clk);
        end
        bus1.S_AXI_AWVALID = 1'b0;
        bus1.S_AXI_WVALID  = 1'b0;
        check("wr1_handshake", 32'(ok), 1);
        @(posedge clk);
        @(negedge clk);
        check("bvalid1", 32'(bus1.S_AXI_BVALID), 1);
        @(posedge clk);
        @(negedge clk);
        bus1.S_AXI_BREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        logic [3:0]  rs;
        intr0 = 4'b0100;
        intr1 = 1'b0;
        {bus0.S_AXI_AWVALID, bus0.S_AXI_WVALID, bus0.S_AXI_BREADY, bus0.S_AXI_ARVALID, bus0.S_AXI_RREADY} = '0;
        {bus1.S_AXI_AWVALID, bus1.S_AXI_WVALID, bus1.S_AXI_BREADY, bus1.S_AXI_ARVALID, bus1.S_AXI_RREADY} = '0;
        bus0.S_AXI_AWADDR = '0; bus0.S_AXI_WDATA = '0; bus0.S_AXI_WSTRB = 4'hF; bus0.S_AXI_ARADDR = '0;
        bus0.S_AXI_AWPROT = '0; bus0.S_AXI_ARPROT = '0;
        bus1.S_AXI_AWADDR = '0; bus1.S_AXI_WDATA = '0; bus1.S_AXI_WSTRB = 4'hF; bus1.S_AXI_ARADDR = '0;
        bus1.S_AXI_AWPROT = '0; bus1.S_AXI_ARPROT = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_awready", 32'(bus0.S_AXI_AWREADY), 0);
        check("rst_wready", 32'(bus0.S_AXI_WREADY), 0);
        check("rst_arready", 32'(bus0.S_AXI_ARREADY), 0);
        check("rst_bvalid", 32'(bus0.S_AXI_BVALID), 0);
        check("rst_rvalid", 32'(bus0.S_AXI_RVALID), 0);
        check("rst_rdata", bus0.S_AXI_RDATA, 0);
        check("rst_resp", {28'b0, bus0.S_AXI_BRESP, bus0.S_AXI_RRESP}, 0);
        check("rst_irq0", 32'(irq0), 0);
        check("rst_irq1", 32'(irq1), 0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 0);

        // edge capture, irq latency, acknowledge
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, '0);
        axi_write(5'h04, 32'h1, 4'hF, 0, 0, 0, '0);
        intr0[0] = 1'b1;
        tick();
        intr0[0] = 1'b0;
        check("irq_lag_one", 32'(irq0), 0);
        tick();
        check("irq_on_two", 32'(irq0), 1);
        axi_read(5'h08, 1);
        axi_read(5'h10, 0);
        axi_write(5'h0C, 32'h1, 4'hF, 0, 0, 1, '0);
        axi_read(5'h10, 0);
        check("irq_after_ack", 32'(irq0), 0);

        // level source masked by IER, then enabled
        axi_write(5'h04, 32'h0, 4'hF, 0, 0, 0, '0);
        intr0[1] = 1'b1;
        repeat (3) tick();
        axi_read(5'h08, 0);
        axi_read(5'h10, 0);
        check("irq_masked", 32'(irq0), 0);
        axi_write(5'h04, 32'h2, 4'hF, 0, 0, 0, '0);
        tick();
        check("irq_unmasked", 32'(irq0), 1);
        intr0[1] = 1'b0;
        axi_write(5'h0C, 32'h2, 4'hF, 0, 0, 0, '0);

        // AW/W ordering with a stalled B channel
        axi_write(5'h04, 32'hA, 4'hF, 3, 0, 4, '0);
        axi_read(5'h04, 0);
        axi_write(5'h04, 32'h5, 4'hF, 0, 3, 4, '0);
        axi_read(5'h04, 0);
        axi_write(5'h04, 32'hF, 4'hF, 0, 0, 4, '0);
        axi_read(5'h04, 2);

        // acknowledge collides with a new rising edge: set wins
        intr0[0] = 1'b1;
        tick();
        intr0[0] = 1'b0;
        tick();
        axi_write(5'h0C, 32'h1, 4'hF, 0, 0, 0, 4'b0001);
        intr0[0] = 1'b0;
        axi_read(5'h08, 0);
        check("isr0_set_wins", 32'(m_isr[0]), 1);

        // randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            intr0 = 4'($urandom);
            ra = {3'($urandom_range(0, 7)), 2'b00};
            case ($urandom_range(0, 2))
                0: begin
                    rs = ($urandom_range(0, 3) == 0) ? 4'hE : 4'hF;
                    axi_write(ra, $urandom, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 3), '0);
                end
                1: axi_read(ra, $urandom_range(0, 2));
                default: repeat ($urandom_range(1, 3)) tick();
            endcase
        end
        intr0 = 4'b0100;
        tick();

        // pulse-mode irq: two edges separated by an acknowledge
        axi1_write(5'h00, 32'h1);
        axi1_write(5'h04, 32'h1);
        intr1 = 1'b1;
        tick();
        check("pulse_lag", 32'(irq1), 0);
        tick();
        check("pulse_on", 32'(irq1), 1);
        tick();
        check("pulse_off", 32'(irq1), 0);
        repeat (3) tick();
        axi1_write(5'h0C, 32'h1);
        intr1 = 1'b0;
        repeat (2) tick();
        intr1 = 1'b1;
        repeat (6) tick();
        check("pulse_count", 32'(p_count), 2);
        check("pulse_width", 32'(p_maxlen), 1);

        // reset in the middle of a write with irq active
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0, '0);
        axi_write(5'h04, 32'hF, 4'hF, 0, 0, 0, '0);
        intr0[1] = 1'b1;
        repeat (2) tick();
        check("irq_before_reset", 32'(irq0), 1);
        bus0.S_AXI_AWADDR = 5'h04; bus0.S_AXI_WDATA = 32'h0; bus0.S_AXI_WSTRB = 4'hF;
        bus0.S_AXI_AWVALID = 1'b1; bus0.S_AXI_WVALID = 1'b1;
        tick();
        bus0.S_AXI_AWVALID = 1'b0; bus0.S_AXI_WVALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_bvalid", 32'(bus0.S_AXI_BVALID), 0);
        check("rst_mid_irq0", 32'(irq0), 0);
        check("rst_mid_awready", 32'(bus0.S_AXI_AWREADY), 0);
        intr0 = 4'b0100;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_resp_after_reset", 32'(bus0.S_AXI_BVALID), 0);
        end
        check("awready_after_reset", 32'(bus0.S_AXI_AWREADY), 1);
        check("irq1_after_reset", 32'(irq1), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
